// File: rtl/neuro_pkg.sv
// Shared types and arithmetic for the LIF neuron array.
// Holds the state encoding, the default widths and the saturating adder.
package neuro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2
    } lif_state_e;

    localparam int DEF_NUM_SYNAPSE = 16;
    localparam int DEF_NUM_NEURONS = 4;
    localparam int DEF_WEIGHT_W    = 8;
    localparam int DEF_POT_W       = 16;
    localparam int DEF_REFRAC_W    = 4;

    // Add two sign-extended operands and clamp to the range of a w-bit signed value (w <= 32).
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int                 w);
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = 33'(a) + 33'(b);
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        if (s > hi)      return hi[31:0];
        else if (s < lo) return lo[31:0];
        else             return s[31:0];
    endfunction

endpackage

// File: rtl/lif_neuron_array_unit.sv
// One leaky integrate-and-fire neuron: membrane potential, saturating accumulate, leak and threshold.
// Optional refractory counter enabled by LIF_REFRACTORY_EN.
module lif_unit
    import neuro_pkg::*;
#(
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int POT_W    = DEF_POT_W,
    parameter int REFRAC_W = DEF_REFRAC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       acc_en_i,
    input  logic                       ev_i,
    input  logic signed [WEIGHT_W-1:0] weight_i,
    input  logic                       fire_en_i,
    input  logic signed [POT_W-1:0]    thresh_i,
    input  logic [3:0]                 leak_shift_i,
    input  logic [REFRAC_W-1:0]        refrac_len_i,
    output logic                       fire_o
);

    logic signed [POT_W-1:0] pot_q, pot_d;
    logic signed [POT_W-1:0] pot_sum;
    logic signed [POT_W-1:0] leaked;
    logic                    blocked;

`ifdef LIF_REFRACTORY_EN
    logic [REFRAC_W-1:0] refrac_q, refrac_d;
    assign blocked = (refrac_q != '0);
`else
    logic unused_refrac;
    assign unused_refrac = ^refrac_len_i;
    assign blocked       = 1'b0;
`endif

    assign pot_sum = POT_W'(sat_add(32'(pot_q), 32'(weight_i), POT_W));
    // A shift of zero means "no leak", not "leak everything".
    assign leaked  = (leak_shift_i == 4'd0) ? pot_q : pot_q - (pot_q >>> leak_shift_i);
    assign fire_o  = fire_en_i && !blocked && (leaked >= thresh_i);

    always_comb begin
        pot_d = pot_q;
        if (acc_en_i && ev_i && !blocked) begin
            pot_d = pot_sum;
        end else if (fire_en_i) begin
            pot_d = (blocked || fire_o) ? '0 : leaked;
        end
    end

`ifdef LIF_REFRACTORY_EN
    always_comb begin
        refrac_d = refrac_q;
        if (fire_en_i) begin
            if (blocked)     refrac_d = refrac_q - 1'b1;
            else if (fire_o) refrac_d = refrac_len_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) refrac_q <= '0;
        else        refrac_q <= refrac_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pot_q <= '0;
        else        pot_q <= pot_d;
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Sequential LIF neuron array: one synapse per cycle, all neurons in parallel, one spike vector per step.
// Define LIF_REFRACTORY_EN to give each neuron a refractory period after firing.
module lif_neuron_array
    import neuro_pkg::*;
#(
    parameter int NUM_SYNAPSE = DEF_NUM_SYNAPSE,
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int WEIGHT_W    = DEF_WEIGHT_W,
    parameter int POT_W       = DEF_POT_W,
    parameter int REFRAC_W    = DEF_REFRAC_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           step_valid,
    output logic                           step_ready,
    input  logic [NUM_SYNAPSE-1:0]         resp_func [NUM_NEURONS],
    input  logic                           w_we,
    input  logic [$clog2(NUM_SYNAPSE)-1:0] w_addr,
    input  logic signed [WEIGHT_W-1:0]     w_data,
    input  logic signed [POT_W-1:0]        threshold,
    input  logic [3:0]                     leak_shift,
    input  logic [REFRAC_W-1:0]            refrac_len,
    output logic [NUM_NEURONS-1:0]         spike_out,
    output logic                           spike_valid
);

    localparam int IDX_W = $clog2(NUM_SYNAPSE);

    lif_state_e                 state_q;
    logic [IDX_W-1:0]           idx_q;
    logic signed [WEIGHT_W-1:0] w_q [NUM_SYNAPSE];
    logic [NUM_SYNAPSE-1:0]     row_q [NUM_NEURONS];
    logic signed [POT_W-1:0]    thresh_q;
    logic [3:0]                 leak_q;
    logic [NUM_NEURONS-1:0]     spike_q;
    logic                       spike_valid_q;
    logic [NUM_NEURONS-1:0]     fire;

    assign step_ready  = (state_q == IDLE);
    assign spike_out   = spike_q;
    assign spike_valid = spike_valid_q;

    // Weight writes land every cycle; the accumulator reads the pre-write value of the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SYNAPSE; i++) w_q[i] <= '0;
        end else if (w_we) begin
            w_q[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            thresh_q      <= '0;
            leak_q        <= '0;
            spike_q       <= '0;
            spike_valid_q <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) row_q[n] <= '0;
        end else begin
            spike_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (step_valid) begin
                        state_q  <= ACCUM;
                        idx_q    <= '0;
                        thresh_q <= threshold;
                        leak_q   <= leak_shift;
                        for (int n = 0; n < NUM_NEURONS; n++) row_q[n] <= resp_func[n];
                    end
                end
                ACCUM: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(NUM_SYNAPSE - 1)) state_q <= FIRE;
                end
                FIRE: begin
                    spike_q       <= fire;
                    spike_valid_q <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : gen_unit
        lif_unit #(
            .WEIGHT_W (WEIGHT_W),
            .POT_W    (POT_W),
            .REFRAC_W (REFRAC_W)
        ) u_unit (
            .clk          (clk),
            .rst_n        (rst_n),
            .acc_en_i     (state_q == ACCUM),
            .ev_i         (row_q[n][idx_q]),
            .weight_i     (w_q[idx_q]),
            .fire_en_i    (state_q == FIRE),
            .thresh_i     (thresh_q),
            .leak_shift_i (leak_q),
            .refrac_len_i (refrac_len),
            .fire_o       (fire[n])
        );
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array with default parameters.
// Refractory expectations apply when LIF_REFRACTORY_EN is defined.
module tb_lif_neuron_array;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               step_valid;
    logic               step_ready;
    logic [15:0]        rows [4];
    logic               w_we;
    logic [3:0]         w_addr;
    logic signed [7:0]  w_data;
    logic signed [15:0] threshold;
    logic [3:0]         leak_shift;
    logic [3:0]         refrac_len;
    logic [3:0]         spike_out;
    logic               spike_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int cnt;
    int snap0, snap1;
    logic [3:0] spk;

    wire signed [15:0] pot0 = dut.gen_unit[0].u_unit.pot_q;
    wire signed [15:0] pot1 = dut.gen_unit[1].u_unit.pot_q;

    lif_neuron_array dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step_valid  (step_valid),
        .step_ready  (step_ready),
        .resp_func   (rows),
        .w_we        (w_we),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .threshold   (threshold),
        .leak_shift  (leak_shift),
        .refrac_len  (refrac_len),
        .spike_out   (spike_out),
        .spike_valid (spike_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_rows(input logic [15:0] r0, input logic [15:0] r1,
                            input logic [15:0] r2, input logic [15:0] r3);
        rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
    endtask

    task automatic write_w(input int addr, input int data);
        @(negedge clk);
        w_we = 1'b1; w_addr = 4'(addr); w_data = 8'(data);
        @(negedge clk);
        w_we = 1'b0;
    endtask

    // Issue one step and wait (bounded) for its spike_valid; lat counts negedges after the transfer edge.
    task automatic run_step(input int thr, input int ls, output int l, output logic [3:0] s);
        @(negedge clk);
        threshold = 16'(thr); leak_shift = 4'(ls); step_valid = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        l = 1;
        while (spike_valid !== 1'b1 && l < 40) begin
            if (l == 17) begin
                snap0 = int'(pot0);
                snap1 = int'(pot1);
            end
            @(negedge clk);
            l++;
        end
        s = spike_out;
    endtask

    initial begin
        rst_n = 1'b0; step_valid = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
        threshold = '0; leak_shift = '0; refrac_len = '0;
        set_rows(16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", int'(step_ready), 1);
        chk("reset_valid", int'(spike_valid), 0);
        chk("reset_spike", int'(spike_out), 0);
        chk("reset_pot0", int'(pot0), 0);

        // Empty step: only latency and quiet outputs.
        run_step(10, 0, lat, spk);
        chk("zero_latency", lat, 18);
        chk("zero_spike", int'(spk), 0);
        chk("zero_pot0", int'(pot0), 0);
        chk("zero_ready_at_valid", int'(step_ready), 1);
        @(negedge clk);
        chk("valid_pulse_width", int'(spike_valid), 0);

        // Four weights of 5 reach threshold 20 exactly.
        for (int i = 0; i < 4; i++) write_w(i, 5);
        set_rows(16'h000F, 16'h0, 16'h0, 16'h0);
        run_step(20, 0, lat, spk);
        chk("fire_spike", int'(spk), 1);
        chk("fire_pot0", int'(pot0), 0);

        set_rows(16'h0003, 16'h0, 16'h0, 16'h0);
        run_step(20, 0, lat, spk);
        chk("sub_spike", int'(spk), 0);
        chk("sub_pot0", int'(pot0), 10);

        // Build pot0 to 64, then leak by 1/4 with step_valid held across the busy period.
        write_w(4, 54);
        set_rows(16'h0010, 16'h0, 16'h0, 16'h0);
        run_step(100, 0, lat, spk);
        chk("build_pot0", int'(pot0), 64);
        set_rows(16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        threshold = 16'sd100; leak_shift = 4'd2; step_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 10) step_valid = 1'b0;
            if (spike_valid === 1'b1) cnt++;
        end
        chk("held_one_step", cnt, 1);
        chk("leak_pot0", int'(pot0), 48);

        write_w(5, -100);
        set_rows(16'h0020, 16'h0, 16'h0, 16'h0);
        run_step(100, 0, lat, spk);
        chk("neg_weight_pot0", int'(pot0), -52);

        // Saturation: 2032 per step, the 17th step pins the potential at 32767.
        for (int i = 0; i < 16; i++) write_w(i, 127);
        set_rows(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        for (int k = 1; k <= 17; k++) begin
            run_step(32767, 0, lat, spk);
            if (k == 16) begin
                chk("sat_pre_pot1", int'(pot1), 32512);
                chk("sat_pre_spike", int'(spk), 0);
            end
            if (k == 17) begin
                chk("sat_pot1", snap1, 32767);
                chk("sat_pot0", snap0, 32767);
                chk("sat_spike", int'(spk), 15);
                chk("sat_post_pot1", int'(pot1), 0);
            end
        end

        // Reset in the middle of accumulation.
        @(negedge clk);
        threshold = 16'sd1; leak_shift = 4'd0; step_valid = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", int'(step_ready), 1);
        chk("midrst_pot1", int'(pot1), 0);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (spike_valid === 1'b1) cnt++;
        end
        chk("midrst_no_valid", cnt, 0);
        run_step(1, 0, lat, spk);
        chk("midrst_weights_zero", int'(spk), 0);
        chk("midrst_pot0", int'(pot0), 0);

        // Threshold 0 with zero potential fires every step unless refractory.
        set_rows(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
`ifdef LIF_REFRACTORY_EN
        refrac_len = 4'd2;
        run_step(0, 0, lat, spk);
        chk("refr_fire1", int'(spk), 15);
        run_step(0, 0, lat, spk);
        chk("refr_block1", int'(spk), 0);
        run_step(0, 0, lat, spk);
        chk("refr_block2", int'(spk), 0);
        run_step(0, 0, lat, spk);
        chk("refr_fire2", int'(spk), 15);
`else
        run_step(0, 0, lat, spk);
        chk("thr0_fire1", int'(spk), 15);
        run_step(0, 0, lat, spk);
        chk("thr0_fire2", int'(spk), 15);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
